// File: rtl/pcpu_top.sv
`default_nettype none
// =============================================================================
// pcpu_top / pcpu_ctrl : minimal 32-bit pseudo-CPU running Euclid GCD out of
// the ctrl.imem ROM. Define PCPU_TRACE_EN for a per-cycle simulation trace.
// Rev 1.0
// =============================================================================

module pcpu_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int IMEM_DEPTH = 16,
  parameter int INSTR_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_b_zero,
  input  logic i_a_lt_b,
  output logic o_sub_ab,
  output logic o_sub_ba,
  output logic o_swap
);

  typedef enum logic [2:0] {
    c_op_nop   = 3'd0,
    c_op_subab = 3'd1,
    c_op_subba = 3'd2,
    c_op_swap  = 3'd3,
    c_op_jmp   = 3'd4,
    c_op_jzb   = 3'd5,
    c_op_jlt   = 3'd6,
    c_op_halt  = 3'd7
  } op_e;

  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Loaded only from outside (hierarchically); never reset.
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [ADDR_W-1:0]  addr;

  logic [INSTR_W-1:0]        w_instr;
  op_e                       w_op;
  logic [ADDR_W-1:0]         w_target;
  logic [INSTR_W-4:ADDR_W]   w_rsvd;
  logic [ADDR_W-1:0]         w_addr_nxt;

  assign w_instr  = imem[addr];
  assign w_op     = op_e'(w_instr[INSTR_W-1 -: 3]);
  assign w_target = w_instr[ADDR_W-1:0];
  assign w_rsvd   = w_instr[INSTR_W-4:ADDR_W];

  always_comb begin
    w_addr_nxt = addr + c_addr_one;
    o_sub_ab   = 1'b0;
    o_sub_ba   = 1'b0;
    o_swap     = 1'b0;
    case (w_op)
      c_op_subab: o_sub_ab = 1'b1;
      c_op_subba: o_sub_ba = 1'b1;
      c_op_swap:  o_swap   = 1'b1;
      c_op_jmp:   w_addr_nxt = w_target;
      c_op_jzb:   if (i_b_zero) w_addr_nxt = w_target;
      c_op_jlt:   if (i_a_lt_b) w_addr_nxt = w_target;
      c_op_halt:  w_addr_nxt = addr;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
    end else if (i_en) begin
      addr <= w_addr_nxt;
    end
  end

  a_rsvd_zero: assert property (@(posedge clk) disable iff (!rst)
    i_en |-> (w_rsvd == '0))
    else $error("pcpu_ctrl: reserved instruction bit set at addr %0d", addr);

endmodule

module pcpu_top #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 4,
  parameter int IMEM_DEPTH = 16,
  parameter int INSTR_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en
);

  // Plain registers only: the outside world loads operands hierarchically.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  logic w_sub_ab;
  logic w_sub_ba;
  logic w_swap;
  logic w_b_zero;
  logic w_a_lt_b;

  assign w_b_zero = (b == '0);
  assign w_a_lt_b = (a < b);

  pcpu_ctrl #(
    .ADDR_W     (ADDR_W),
    .IMEM_DEPTH (IMEM_DEPTH),
    .INSTR_W    (INSTR_W)
  ) ctrl (
    .clk      (clk),
    .rst      (rst),
    .i_en     (en),
    .i_b_zero (w_b_zero),
    .i_a_lt_b (w_a_lt_b),
    .o_sub_ab (w_sub_ab),
    .o_sub_ba (w_sub_ba),
    .o_swap   (w_swap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= '0;
      b <= '0;
    end else if (en) begin
      if (w_sub_ab) a <= a - b;
      if (w_sub_ba) b <= b - a;
      if (w_swap) begin
        a <= b;
        b <= a;
      end
    end
  end

`ifdef PCPU_TRACE_EN
  always @(posedge clk) begin
    if (rst && en)
      $display("pcpu: addr=%0d op=%0d a=%0h b=%0h", ctrl.addr, ctrl.w_op, a, b);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcpu_top.sv
`default_nettype none
// tb_pcpu_top: scoreboard bench for the GCD pseudo-CPU (operands and program
// are loaded hierarchically, results read back through dut.a / dut.b).
module tb_pcpu_top;

  logic clk = 1'b0;
  logic rst;
  logic en;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  addr;
  } exp_t;

  exp_t sb[$];

  pcpu_top dut (
    .clk (clk),
    .rst (rst),
    .en  (en)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 32'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic load_std();
    for (int i = 0; i < 16; i++) dut.ctrl.imem[i] = 8'b000_0_0000;
    dut.ctrl.imem[0] = 8'b101_0_1001;  // JZB 9
    dut.ctrl.imem[1] = 8'b110_0_0100;  // JLT 4
    dut.ctrl.imem[2] = 8'b001_0_0000;  // SUBAB
    dut.ctrl.imem[3] = 8'b100_0_0000;  // JMP 0
    dut.ctrl.imem[4] = 8'b011_0_0000;  // SWAP
    dut.ctrl.imem[5] = 8'b100_0_0000;  // JMP 0
    dut.ctrl.imem[9] = 8'b111_0_0000;  // HALT
  endtask

  task automatic load_mix();
    for (int i = 0; i < 16; i++) dut.ctrl.imem[i] = 8'b000_0_0000;
    dut.ctrl.imem[0]  = 8'b110_0_1110; // JLT 14
    dut.ctrl.imem[1]  = 8'b111_0_0000; // HALT
    dut.ctrl.imem[14] = 8'b010_0_0000; // SUBBA
    dut.ctrl.imem[15] = 8'b011_0_0000; // SWAP, then wraps to 0
  endtask

  task automatic do_reset();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start(input logic [31:0] a0, input logic [31:0] b0);
    do_reset();
    dut.a = a0;
    dut.b = b0;
    en = 1'b1;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dut.ctrl.addr == 4'd9) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    dut.a = 32'h1234_5678;
    dut.b = 32'h9abc_def0;
    dut.ctrl.addr = 4'd5;
    sb.push_back('{"reset", 32'd0, 32'd0, 4'd0});
    #2 rst = 1'b0;
    #1;
    e = sb.pop_front();
    n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.a: got %0h required %0h", e.name, dut.a, e.a); end
    n_vec++; if (dut.b !== e.b) begin n_miss++; $display("FAIL %s.b: got %0h required %0h", e.name, dut.b, e.b); end
    n_vec++; if (dut.ctrl.addr !== e.addr) begin n_miss++; $display("FAIL %s.addr: got %0d required %0d", e.name, dut.ctrl.addr, e.addr); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  // SUBBA, simultaneous SWAP, JLT both ways, PC wrap 15->0 and HALT hold.
  task automatic test_isa_mix();
    exp_t e;
    load_mix();
    start(32'd3, 32'd10);
    sb.push_back('{"mix", 32'd7, 32'd3, 4'd1});
    sb.push_back('{"mix_hold", 32'd7, 32'd3, 4'd1});
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.a: got %0h required %0h", e.name, dut.a, e.a); end
      n_vec++; if (dut.b !== e.b) begin n_miss++; $display("FAIL %s.b: got %0h required %0h", e.name, dut.b, e.b); end
      n_vec++; if (dut.ctrl.addr !== e.addr) begin n_miss++; $display("FAIL %s.addr: got %0d required %0d", e.name, dut.ctrl.addr, e.addr); end
      repeat (4) @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic test_gcd();
    logic [31:0] va [7] = '{32'd48, 32'd17, 32'd0, 32'd7, 32'd0, 32'hFFFF_FFFE, 32'd5};
    logic [31:0] vb [7] = '{32'd18, 32'd5,  32'd7, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd17};
    exp_t e;
    bit   ok;
    load_std();
    for (int v = 0; v < 7; v++) begin
      start(va[v], vb[v]);
      sb.push_back('{$sformatf("gcd(%0h,%0h)", va[v], vb[v]), gcd_ref(va[v], vb[v]), 32'd0, 4'd9});
      wait_halt(1000, ok);
      e = sb.pop_front();
      n_vec++; if (!ok) begin n_miss++; $display("FAIL %s.halt: got timeout required addr 9", e.name); end
      n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.a: got %0h required %0h", e.name, dut.a, e.a); end
      n_vec++; if (dut.b !== e.b) begin n_miss++; $display("FAIL %s.b: got %0h required %0h", e.name, dut.b, e.b); end
      repeat (10) @(negedge clk);
      n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.hold_a: got %0h required %0h", e.name, dut.a, e.a); end
      n_vec++; if (dut.ctrl.addr !== e.addr) begin n_miss++; $display("FAIL %s.hold_addr: got %0d required %0d", e.name, dut.ctrl.addr, e.addr); end
    end
    en = 1'b0;
  endtask

  // Near-wrap operands: 50 loop iterations of 4 instructions each, a drops by 2 each.
  task automatic test_overflow();
    exp_t e;
    start(32'hFFFF_FFFE, 32'd2);
    sb.push_back('{"ovf", 32'hFFFF_FF9A, 32'd2, 4'd0});
    repeat (200) @(negedge clk);
    e = sb.pop_front();
    n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.a: got %0h required %0h", e.name, dut.a, e.a); end
    n_vec++; if (dut.b !== e.b) begin n_miss++; $display("FAIL %s.b: got %0h required %0h", e.name, dut.b, e.b); end
    n_vec++; if (dut.ctrl.addr !== e.addr) begin n_miss++; $display("FAIL %s.addr: got %0d required %0d", e.name, dut.ctrl.addr, e.addr); end
    en = 1'b0;
  endtask

  // 48,18 after 7 instructions: two SUBABs done, sitting at addr 3 with a=12.
  task automatic test_freeze();
    exp_t e;
    bit   ok;
    start(32'd48, 32'd18);
    sb.push_back('{"freeze_pre", 32'd12, 32'd18, 4'd3});
    sb.push_back('{"freeze_hold", 32'd12, 32'd18, 4'd3});
    sb.push_back('{"freeze_resume", 32'd6, 32'd0, 4'd9});
    repeat (7) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.a: got %0h required %0h", e.name, dut.a, e.a); end
      n_vec++; if (dut.b !== e.b) begin n_miss++; $display("FAIL %s.b: got %0h required %0h", e.name, dut.b, e.b); end
      n_vec++; if (dut.ctrl.addr !== e.addr) begin n_miss++; $display("FAIL %s.addr: got %0d required %0d", e.name, dut.ctrl.addr, e.addr); end
      repeat (5) @(negedge clk);
    end
    en = 1'b1;
    wait_halt(1000, ok);
    e = sb.pop_front();
    n_vec++; if (!ok) begin n_miss++; $display("FAIL %s.halt: got timeout required addr 9", e.name); end
    n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.a: got %0h required %0h", e.name, dut.a, e.a); end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    start(32'd48, 32'd18);
    sb.push_back('{"rst_mid", 32'd0, 32'd0, 4'd0});
    sb.push_back('{"rst_restart", 32'd0, 32'd0, 4'd9});
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    e = sb.pop_front();
    n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.a: got %0h required %0h", e.name, dut.a, e.a); end
    n_vec++; if (dut.b !== e.b) begin n_miss++; $display("FAIL %s.b: got %0h required %0h", e.name, dut.b, e.b); end
    n_vec++; if (dut.ctrl.addr !== e.addr) begin n_miss++; $display("FAIL %s.addr: got %0d required %0d", e.name, dut.ctrl.addr, e.addr); end
    @(negedge clk);
    rst = 1'b1;
    // From addr 0 with b=0 the first instruction (JZB 9) lands on HALT.
    @(negedge clk);
    e = sb.pop_front();
    n_vec++; if (dut.ctrl.addr !== e.addr) begin n_miss++; $display("FAIL %s.addr: got %0d required %0d", e.name, dut.ctrl.addr, e.addr); end
    n_vec++; if (dut.a !== e.a) begin n_miss++; $display("FAIL %s.a: got %0h required %0h", e.name, dut.a, e.a); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_isa_mix();
    test_gcd();
    test_overflow();
    test_freeze();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
